// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART arbiter state encoding and frame constants
package uart_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'd0,
      ARB_LOAD  = 3'd1,
      ARB_START = 3'd2,
      ARB_WAIT  = 3'd3,
      ARB_ACK   = 3'd4
   } arb_state_t;

   // 8N1 frame: 10 bits of 16 oversample ticks each
   localparam int UART_FRAME_TICKS = 160;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// rtl/uart_tx_arbiter_rr_select.sv - combinational round-robin picker, first set bit at or above i_rr_ptr with wrap
module rr_select #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_rr_ptr,
   output logic [IDX_W-1:0] o_grant,
   output logic             o_valid
);

   logic [IDX_W-1:0] w_idx;

   // Scan from the farthest offset down so the closest set bit to i_rr_ptr wins last
   always_comb begin
      o_grant = '0;
      o_valid = |i_req;
      w_idx   = '0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         w_idx = IDX_W'((int'(i_rr_ptr) + off) % N_REQ);
         if (i_req[w_idx]) begin
            o_grant = w_idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one 8N1 UART TX among N_REQ byte clients
// Optional per-frame abort timer is built only when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int TIMEOUT_TICKS = 255
) (
   input  logic               CLK_100MHZ,
   input  logic               reset,
   input  logic               clk_en_16_x_baud,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   ack,
   output logic               busy,
   output logic [7:0]         tx_data,
   output logic               tx_send,
   input  logic               tx_done,
   output logic               tx_timeout
);

   localparam int IDX_W = $clog2(N_REQ);

   arb_state_t       r_state;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] r_grant;
   logic [N_REQ-1:0] r_ack;
   logic             r_busy;
   logic [7:0]       r_tx_data;
   logic             r_tx_send;
   logic             r_tx_timeout;
   logic             r_done_q;

   wire [IDX_W-1:0]  w_grant;
   wire              w_valid;
   wire [IDX_W-1:0]  w_next_ptr = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
   wire              w_done_rise = tx_done & ~r_done_q;
   wire              w_tmo_hit;

   rr_select #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_select (
      .i_req    (req),
      .i_rr_ptr (r_rr_ptr),
      .o_grant  (w_grant),
      .o_valid  (w_valid)
   );

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

   logic [TMO_W-1:0] r_tmo_cnt;

   assign w_tmo_hit = ((r_state == ARB_START) || (r_state == ARB_WAIT)) && clk_en_16_x_baud &&
                      (r_tmo_cnt == TMO_W'(TIMEOUT_TICKS - 1));

   // LOAD always precedes START, so clearing there restarts the count per frame
   always_ff @(posedge CLK_100MHZ) begin
      if (reset) begin
         r_tmo_cnt <= '0;
      end else if (r_state == ARB_LOAD) begin
         r_tmo_cnt <= '0;
      end else if (((r_state == ARB_START) || (r_state == ARB_WAIT)) && clk_en_16_x_baud) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end
`else
   wire w_unused_tmo = (TIMEOUT_TICKS > 0);

   assign w_tmo_hit = 1'b0;
`endif

   always_ff @(posedge CLK_100MHZ) begin
      if (reset) begin
         r_state      <= ARB_IDLE;
         r_rr_ptr     <= '0;
         r_grant      <= '0;
         r_ack        <= '0;
         r_busy       <= 1'b0;
         r_tx_data    <= 8'h00;
         r_tx_send    <= 1'b0;
         r_tx_timeout <= 1'b0;
         r_done_q     <= 1'b0;
      end else begin
         r_done_q     <= tx_done;
         r_ack        <= '0;
         r_tx_timeout <= 1'b0;
         case (r_state)
            ARB_IDLE: begin
               if (w_valid) begin
                  r_grant <= w_grant;
                  r_busy  <= 1'b1;
                  r_state <= ARB_LOAD;
               end
            end
            ARB_LOAD: begin
               r_tx_data <= req_data[{r_grant, 3'b000} +: 8];
               r_tx_send <= 1'b1;
               r_state   <= ARB_START;
            end
            ARB_START, ARB_WAIT: begin
               if (w_tmo_hit) begin
                  r_tx_timeout <= 1'b1;
                  r_tx_send    <= 1'b0;
                  r_rr_ptr     <= w_next_ptr;
                  r_busy       <= 1'b0;
                  r_state      <= ARB_IDLE;
               end else if (r_state == ARB_START) begin
                  // Hold send until the TX has seen it on an enable tick
                  if (clk_en_16_x_baud) begin
                     r_tx_send <= 1'b0;
                     r_state   <= ARB_WAIT;
                  end
               end else if (w_done_rise) begin
                  r_ack[r_grant] <= 1'b1;
                  r_state        <= ARB_ACK;
               end
            end
            ARB_ACK: begin
               r_rr_ptr <= w_next_ptr;
               r_busy   <= 1'b0;
               r_state  <= ARB_IDLE;
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign ack        = r_ack;
   assign busy       = r_busy;
   assign tx_data    = r_tx_data;
   assign tx_send    = r_tx_send;
   assign tx_timeout = r_tx_timeout;

endmodule
